// File: rtl/dma_controller_mc.sv
// dma_controller_mc: multi-channel RAM<->DRAM DMA with round-robin arbitration per 32-bit word.
// Optional channel abort (CONTROL bit2) is compiled in with `define DMA_ABORT_EN.
module dma_controller_mc #(
  parameter int NUM_CH  = 2,
  parameter int COUNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        write_enable,
  output logic [15:0] data_out,
  output logic        dma_status,
  output logic        irq,
  output logic [15:0] ram_addr,
  input  logic [15:0] ram_data_in,
  output logic [15:0] ram_data_out,
  output logic        ram_we,
  output logic [23:0] dram_addr,
  input  logic [31:0] dram_data_in,
  output logic [31:0] dram_data_out,
  output logic        dram_req_read,
  output logic        dram_req_write,
  input  logic        dram_data_valid,
  input  logic        dram_write_complete
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GBASE = NUM_CH * 8;

  typedef enum logic [2:0] {
    IDLE, RAM_RD0, RAM_RD1, DRAM_WR,
    DRAM_RD, RAM_WR0, RAM_WR1, UPDATE
  } state_t;

  state_t state, state_nx;

  logic [COUNT_W-1:0] count [NUM_CH];
  logic [23:0]        periph [NUM_CH];
  logic [15:0]        lcl [NUM_CH];
  logic [NUM_CH-1:0]  dir, irq_en, busy, pending;
`ifdef DMA_ABORT_EN
  logic [NUM_CH-1:0]  abort_req;
`endif
  logic [CW-1:0] cur, last, gnt;
  logic          gnt_ok;
  logic [31:0]   buffer;
  logic          hi_ok;
  logic [15:0]   rd_val;
  logic          wr, rd;

  assign wr = en && write_enable;
  assign rd = en && !write_enable;
  assign dma_status = |busy;
  assign irq = |(pending & irq_en);

  // first busy channel strictly after the last one served
  always_comb begin
    gnt_ok = 1'b0;
    gnt = last;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!gnt_ok && busy[CW'((int'(last) + i) % NUM_CH)]) begin
        gnt_ok = 1'b1;
        gnt = CW'((int'(last) + i) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_ok) state_nx = dir[gnt] ? DRAM_RD : RAM_RD0;
      RAM_RD0: state_nx = RAM_RD1;
      RAM_RD1: state_nx = DRAM_WR;
      DRAM_WR: if (dram_write_complete) state_nx = UPDATE;
      DRAM_RD: if (dram_data_valid) state_nx = RAM_WR0;
      RAM_WR0: state_nx = RAM_WR1;
      RAM_WR1: state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = '0;
    ram_data_out = '0;
    ram_we = 1'b0;
    dram_addr = '0;
    dram_data_out = '0;
    dram_req_read = 1'b0;
    dram_req_write = 1'b0;
    unique case (state)
      RAM_RD0: ram_addr = lcl[cur];
      RAM_RD1: ram_addr = lcl[cur] + 16'd1;
      DRAM_WR: begin
        ram_addr = lcl[cur] + 16'd1;
        dram_req_write = 1'b1;
        dram_addr = periph[cur];
        // high half arrives in the first DRAM_WR cycle, held afterwards
        dram_data_out = {hi_ok ? buffer[31:16] : ram_data_in, buffer[15:0]};
      end
      DRAM_RD: begin
        dram_req_read = 1'b1;
        dram_addr = periph[cur];
      end
      RAM_WR0: begin
        ram_addr = lcl[cur];
        ram_we = 1'b1;
        ram_data_out = buffer[15:0];
      end
      RAM_WR1: begin
        ram_addr = lcl[cur] + 16'd1;
        ram_we = 1'b1;
        ram_data_out = buffer[31:16];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr[15:3] == 13'(c)) begin
        case (addr[2:0])
          3'd0: rd_val = 16'(count[c]);
          3'd1: rd_val = periph[c][15:0];
          3'd2: rd_val = {8'h00, periph[c][23:16]};
          3'd3: rd_val = lcl[c];
          3'd4: rd_val = {14'd0, irq_en[c], dir[c]};
          default: rd_val = '0;
        endcase
      end
    end
    if (addr == 16'(GBASE))     rd_val = 16'(busy);
    if (addr == 16'(GBASE + 1)) rd_val = 16'(pending);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count[c]  <= '0;
        periph[c] <= '0;
        lcl[c]    <= '0;
      end
      dir      <= '0;
      irq_en   <= '0;
      busy     <= '0;
      pending  <= '0;
`ifdef DMA_ABORT_EN
      abort_req <= '0;
`endif
      cur      <= '0;
      last     <= CW'(NUM_CH - 1);
      buffer   <= '0;
      hi_ok    <= 1'b0;
      data_out <= '0;
    end else begin
      if (state == IDLE && gnt_ok) cur <= gnt;
      if (state == UPDATE) last <= cur;
      if (state == RAM_RD1) buffer[15:0] <= ram_data_in;
      if (state == DRAM_WR && !hi_ok) buffer[31:16] <= ram_data_in;
      hi_ok <= (state == DRAM_WR);
      if (state == DRAM_RD && dram_data_valid) buffer <= dram_data_in;
      if (rd) data_out <= rd_val;
      if (wr && addr == 16'(GBASE + 1))
        pending <= pending & ~data_in[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr && addr[15:3] == 13'(c) && !busy[c]) begin
          case (addr[2:0])
            3'd0: count[c] <= COUNT_W'(data_in);
            3'd1: periph[c][15:0] <= data_in;
            3'd2: periph[c][23:16] <= data_in[7:0];
            3'd3: lcl[c] <= data_in;
            3'd4: begin
              dir[c] <= data_in[0];
              irq_en[c] <= data_in[1];
              if (count[c] != '0) busy[c] <= 1'b1;
              else                pending[c] <= 1'b1;
`ifdef DMA_ABORT_EN
              abort_req[c] <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
        if (state == UPDATE && cur == CW'(c)) begin
          periph[c] <= periph[c] + 24'd1;
          lcl[c] <= lcl[c] + 16'd2;
          count[c] <= count[c] - COUNT_W'(1);
          if (count[c] == COUNT_W'(1)) begin
            busy[c] <= 1'b0;
            pending[c] <= 1'b1;
          end
`ifdef DMA_ABORT_EN
          else if (abort_req[c]) busy[c] <= 1'b0;
          abort_req[c] <= 1'b0;
`endif
        end
`ifdef DMA_ABORT_EN
        // an in-flight unit finishes first; a parked channel just drops busy
        if (wr && addr[15:3] == 13'(c) && addr[2:0] == 3'd4 &&
            busy[c] && data_in[2]) begin
          if ((state != IDLE && cur == CW'(c)) ||
              (state == IDLE && gnt_ok && gnt == CW'(c)))
            abort_req[c] <= 1'b1;
          else
            busy[c] <= 1'b0;
        end
`endif
      end
    end
  end
endmodule
